fft_state5: RTL and testbench
=============================

Name: fft_state5

Overview:
- Final radix-2 stage of the 32-point MDC FFT. Sits directly downstream of stage 4.
- Consumes stage-4 up/lower complex streams: 16 sample pairs per frame.
- Applies the distance-1 butterflies. This stage has no twiddle multiply.
- Owns its control counter: a local phase counter replaces externally supplied commutator/butterfly mode signals.
- Emits full-precision results with valid/last framing to the output reorder logic.

Parameters:
- WIDTH, 9, bit width of each input real/imag component (signed two's complement).
- PAIRS, 16, sample pairs per frame (32 points / 2 paths).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input pair present this cycle.
- in_sof  input  1  qualified by in_valid; marks pair index 0 of a frame.
- in_up_re, in_up_im  input  WIDTH  upper-path sample from stage 4.
- in_l_re, in_l_im  input  WIDTH  lower-path sample from stage 4.
- out_valid  output  1  result pair valid.
- out_sel  output  1  0 = upper-path butterfly result, 1 = lower-path butterfly result.
- out_last  output  1  final result of the frame.
- out_up_re, out_up_im  output  WIDTH+1  butterfly sum.
- out_l_re, out_l_im  output  WIDTH+1  butterfly difference.

Behaviour:
- Single clock domain. rst is synchronous and active-high.
- Reset state: out_valid, out_sel, out_last = 0; all data outputs = 0; pair counter = 0; pending-lower flag = 0; hold registers = 0.
- Pair counter k (log2(PAIRS) bits):
  - Increments on each in_valid and wraps 15 -> 0.
  - in_valid with in_sof forces k = 0 for that pair; the counter then continues from 1.
- Even k (cycle t):
  - Capture U_even = in_up and L_even = in_l into hold registers.
  - No output is produced for an even pair.
- Odd k (cycle t):
  - Compute sum = U_even + in_up and diff = U_even - in_up, sign-extended to WIDTH+1 bits; no truncation, cannot overflow.
  - Register the result: at t+1, out_valid = 1, out_sel = 0.
  - Capture L_odd = in_l and set pending-lower.
- Pending-lower (cycle t+1):
  - Compute L_even + L_odd and L_even - L_odd.
  - Register the result: at t+2, out_valid = 1, out_sel = 1. Clear pending.
  - This emission is unconditional: it happens whether or not in_valid is asserted at t+1.
  - A new even pair arriving at t+1 may overwrite the L_even hold register in the same edge; the butterfly uses the pre-edge value.
- Collisions: none possible. Odd pairs are at least 2 cycles apart, so upper and lower emissions never coincide. With continuous in_valid the output is valid every cycle after the first 2-cycle fill.
- Latency: upper result 1 cycle after the odd input; lower result 2 cycles after it.
- out_last = 1 together with the out_sel = 1 result of pair k = 15. That makes 16 results per frame.
- Idle cycles: out_valid = 0. Data outputs hold their last value.
- in_sof arriving while an even sample is held (the expected odd partner never came):
  - The held even sample is discarded.
  - The new pair is treated as k = 0.
  - A pending-lower emission already scheduled still completes.
- rst asserted mid-frame: the pending-lower emission is cancelled; no output in the cycle after reset deasserts; the counter restarts at 0.
- in_sof without in_valid is ignored.

Decomposition:
- Shared package fft_pkg:
  - FFT_POINTS = 32, FFT_PAIRS = 16, DATA_WIDTH = 9.
  - A complex-sample struct typedef (re/im signed) parameterised via WIDTH.
- One natural sub-module: fft_bf2. Purely combinational complex add/sub, WIDTH in, WIDTH+1 out. Instantiated twice (upper path, lower path), or once with an input mux selected by pending-lower.
- Control (counter, hold registers, pending flag, output registers) lives in fft_state5.

Test Plan:
- Reset: hold rst = 1 for 3 cycles with random inputs and in_valid = 1 -> out_valid = 0 and all outputs 0 throughout; first pair after release is k = 0.
- Basic pair:
  - Stimulus: U0 = (10,-3), L0 = (5,7), then U1 = (4,1), L1 = (-2,2) on consecutive cycles.
  - Next cycle: out_up = (14,-2), out_l = (6,-4), sel = 0.
  - Following cycle: out_up = (3,9), out_l = (7,5), sel = 1.
- Extremes:
  - Stimulus: U0 = U1 = (255,-256), L0 = (-256,255), L1 = (255,-256).
  - Upper result: (510,-512)/(0,0).
  - Lower result: (-1,-1)/(-511,511), all exact in 10 bits.
- Full frames:
  - Stimulus: 32 consecutive valid pairs, in_sof on pairs 0 and 16.
  - Response: 32 consecutive out_valid cycles starting 1 cycle after pair 1. out_sel alternates 0/1. out_last pulses exactly on results 16 and 32.
- Gaps:
  - Stimulus: even pair; 3 idle cycles; odd pair with in_valid dropping immediately after.
  - Response: correct upper result at +1 and lower result at +2 despite in_valid = 0.
- Resync/reset:
  - in_sof on an odd-position pair -> it is treated as k = 0; prior even discarded; no output that cycle.
  - rst asserted the cycle after an odd input -> no sel = 1 output appears.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: constants and complex-sample types shared by the 32-point MDC FFT
// pipeline stages.
//   FFT_POINTS  : transform length
//   FFT_PAIRS   : sample pairs per frame (two parallel paths)
//   DATA_WIDTH  : width of each real/imag component entering the last stage
package fft_pkg;

  localparam int FFT_POINTS = 32;
  localparam int FFT_PAIRS  = 16;
  localparam int DATA_WIDTH = 9;

  // Complex sample at the stage input width.
  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } cplx_t;

  // Complex sample after one butterfly: one bit of growth.
  typedef struct packed {
    logic signed [DATA_WIDTH:0] re;
    logic signed [DATA_WIDTH:0] im;
  } cplx_wide_t;

endpackage

// File: rtl/fft_state5_if.sv
// fft_state5_if: stream bundle between stage 4, the final butterfly stage and
// the output reorder logic.
//   in_valid/in_sof, in_up_*, in_l_*    : stage-4 upper/lower pair + framing
//   out_valid/out_sel/out_last          : result framing
//   out_up_* (sum), out_l_* (difference): butterfly results, WIDTH+1 bits
//
// Handshake: valid-only streams with no backpressure. A beat transfers on
// every rising clock edge where its valid is high; in_sof and all data are
// meaningful only in that cycle and are ignored otherwise. The consumer of the
// output stream must accept a result on every cycle out_valid is high.
interface fft_state5_if #(
  parameter int WIDTH = fft_pkg::DATA_WIDTH
);
  logic                    in_valid;
  logic                    in_sof;
  logic signed [WIDTH-1:0] in_up_re;
  logic signed [WIDTH-1:0] in_up_im;
  logic signed [WIDTH-1:0] in_l_re;
  logic signed [WIDTH-1:0] in_l_im;
  logic                    out_valid;
  logic                    out_sel;
  logic                    out_last;
  logic signed [WIDTH:0]   out_up_re;
  logic signed [WIDTH:0]   out_up_im;
  logic signed [WIDTH:0]   out_l_re;
  logic signed [WIDTH:0]   out_l_im;

  // Producer side (stage 4 / bench) and result consumer.
  modport master (
    output in_valid, in_sof, in_up_re, in_up_im, in_l_re, in_l_im,
    input  out_valid, out_sel, out_last, out_up_re, out_up_im, out_l_re, out_l_im
  );

  // The butterfly stage itself.
  modport slave (
    input  in_valid, in_sof, in_up_re, in_up_im, in_l_re, in_l_im,
    output out_valid, out_sel, out_last, out_up_re, out_up_im, out_l_re, out_l_im
  );
endinterface

// File: rtl/fft_bf2.sv
// fft_bf2: combinational radix-2 complex butterfly, no twiddle.
//   a_re/a_im, b_re/b_im        : WIDTH-bit signed operands
//   sum_re/sum_im   = a + b     : WIDTH+1 bits, exact
//   diff_re/diff_im = a - b     : WIDTH+1 bits, exact
module fft_bf2 #(
  parameter int WIDTH = 9
) (
  input  logic signed [WIDTH-1:0] a_re,
  input  logic signed [WIDTH-1:0] a_im,
  input  logic signed [WIDTH-1:0] b_re,
  input  logic signed [WIDTH-1:0] b_im,
  output logic signed [WIDTH:0]   sum_re,
  output logic signed [WIDTH:0]   sum_im,
  output logic signed [WIDTH:0]   diff_re,
  output logic signed [WIDTH:0]   diff_im
);
  // Operands are sign-extended first so the extra bit absorbs any carry.
  assign sum_re  = {a_re[WIDTH-1], a_re} + {b_re[WIDTH-1], b_re};
  assign sum_im  = {a_im[WIDTH-1], a_im} + {b_im[WIDTH-1], b_im};
  assign diff_re = {a_re[WIDTH-1], a_re} - {b_re[WIDTH-1], b_re};
  assign diff_im = {a_im[WIDTH-1], a_im} - {b_im[WIDTH-1], b_im};
endmodule

// File: rtl/fft_state5.sv
// fft_state5: final radix-2 stage of the 32-point MDC FFT (distance-1
// butterflies, no twiddle).
//   clk, rst : clock and synchronous active-high reset
//   bus      : fft_state5_if slave modport (stage-4 input pairs, results out)
// Even pairs are held; an odd pair emits the upper-path butterfly one cycle
// later (out_sel = 0) and the lower-path butterfly the cycle after that
// (out_sel = 1). out_last marks the lower result of pair 15.
module fft_state5
  import fft_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int PAIRS = FFT_PAIRS
) (
  input  logic         clk,
  input  logic         rst,
  fft_state5_if.slave  bus
);
  localparam int KW = $clog2(PAIRS);

  logic [KW-1:0]           k_q;
  logic [KW-1:0]           k_cur;
  logic                    is_odd;
  logic                    is_even;
  logic                    is_last_pair;
  logic                    pend_q;
  logic                    pend_last_q;
  logic signed [WIDTH-1:0] u_even_re_q, u_even_im_q;
  logic signed [WIDTH-1:0] l_even_re_q, l_even_im_q;
  logic signed [WIDTH-1:0] l_odd_re_q,  l_odd_im_q;
  logic signed [WIDTH-1:0] a_re, a_im, b_re, b_im;
  logic signed [WIDTH:0]   sum_re, sum_im, diff_re, diff_im;

  // Index of the pair on the bus this cycle; in_sof resynchronises to 0,
  // which also discards an even sample still waiting for its partner.
  always_comb begin
    k_cur        = bus.in_sof ? '0 : k_q;
    is_odd       = bus.in_valid & k_cur[0];
    is_even      = bus.in_valid & ~k_cur[0];
    is_last_pair = (k_cur == KW'(PAIRS - 1));
  end

  // One shared butterfly. A pending lower emission and an odd input can never
  // coincide (the pair after an odd one is always even), so pend_q alone
  // picks the operands.
  always_comb begin
    a_re = u_even_re_q;
    a_im = u_even_im_q;
    b_re = bus.in_up_re;
    b_im = bus.in_up_im;
    if (pend_q) begin
      a_re = l_even_re_q;
      a_im = l_even_im_q;
      b_re = l_odd_re_q;
      b_im = l_odd_im_q;
    end
  end

  fft_bf2 #(.WIDTH(WIDTH)) u_bf2 (
    .a_re    (a_re),
    .a_im    (a_im),
    .b_re    (b_re),
    .b_im    (b_im),
    .sum_re  (sum_re),
    .sum_im  (sum_im),
    .diff_re (diff_re),
    .diff_im (diff_im)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q           <= '0;
      pend_q        <= 1'b0;
      pend_last_q   <= 1'b0;
      u_even_re_q   <= '0;
      u_even_im_q   <= '0;
      l_even_re_q   <= '0;
      l_even_im_q   <= '0;
      l_odd_re_q    <= '0;
      l_odd_im_q    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sel   <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_up_re <= '0;
      bus.out_up_im <= '0;
      bus.out_l_re  <= '0;
      bus.out_l_im  <= '0;
    end else begin
      if (bus.in_valid) begin
        k_q <= k_cur + 1'b1;
      end
      // The pending butterfly reads l_even_* before this edge, so an even
      // pair landing in the same cycle may safely overwrite it.
      if (is_even) begin
        u_even_re_q <= bus.in_up_re;
        u_even_im_q <= bus.in_up_im;
        l_even_re_q <= bus.in_l_re;
        l_even_im_q <= bus.in_l_im;
      end
      if (is_odd) begin
        l_odd_re_q  <= bus.in_l_re;
        l_odd_im_q  <= bus.in_l_im;
        pend_last_q <= is_last_pair;
      end
      pend_q        <= is_odd;
      bus.out_valid <= is_odd | pend_q;
      bus.out_sel   <= pend_q;
      bus.out_last  <= pend_q & pend_last_q;
      // Data registers hold their last result through idle cycles.
      if (is_odd | pend_q) begin
        bus.out_up_re <= sum_re;
        bus.out_up_im <= sum_im;
        bus.out_l_re  <= diff_re;
        bus.out_l_im  <= diff_im;
      end
    end
  end

endmodule

// File: tb/tb_fft_state5.sv
// tb_fft_state5: directed bench for fft_state5 with hand-computed expectations
// and a small expected-result queue for the full-frame run.
module tb_fft_state5;
  import fft_pkg::*;

  localparam int W = DATA_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_state5_if #(.WIDTH(W)) bus ();

  fft_state5 #(.WIDTH(W), .PAIRS(FFT_PAIRS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic sel;
    logic last;
    int   ure, uim, lre, lim;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input logic sel, input logic last,
                         input int ure, input int uim, input int lre, input int lim);
    chk({tag, ".valid"}, {31'd0, bus.out_valid}, 1);
    chk({tag, ".sel"},   {31'd0, bus.out_sel},   {31'd0, sel});
    chk({tag, ".last"},  {31'd0, bus.out_last},  {31'd0, last});
    chk({tag, ".up_re"}, 32'($signed(bus.out_up_re)), ure);
    chk({tag, ".up_im"}, 32'($signed(bus.out_up_im)), uim);
    chk({tag, ".l_re"},  32'($signed(bus.out_l_re)),  lre);
    chk({tag, ".l_im"},  32'($signed(bus.out_l_im)),  lim);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, {31'd0, bus.out_valid}, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic sof, input int ur, input int ui,
                       input int lr, input int li);
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_up_re = W'(ur);
    bus.in_up_im = W'(ui);
    bus.in_l_re  = W'(lr);
    bus.in_l_im  = W'(li);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  // Outputs are sampled 1 time unit after the edge that produced them.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd9();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int   ur, ui, lr, li;
    int   pur, pui, plr, pli;
    exp_t e;

    // Reset with live random traffic: nothing may come out.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), rnd9(), rnd9(), rnd9(), rnd9());
      tick();
      chk_idle($sformatf("reset%0d", i));
      chk($sformatf("reset%0d.sel", i),   {31'd0, bus.out_sel}, 0);
      chk($sformatf("reset%0d.last", i),  {31'd0, bus.out_last}, 0);
      chk($sformatf("reset%0d.up_re", i), 32'($signed(bus.out_up_re)), 0);
      chk($sformatf("reset%0d.l_im", i),  32'($signed(bus.out_l_im)), 0);
    end
    rst = 1'b0;

    // Basic pair; no in_sof, so the counter must start at 0 after reset.
    drive(1'b1, 1'b0, 10, -3, 5, 7);
    tick();
    chk_idle("basic_even");
    drive(1'b1, 1'b0, 4, 1, -2, 2);
    tick();
    idle();
    chk_out("basic_up", 1'b0, 1'b0, 14, -2, 6, -4);
    tick();
    chk_out("basic_lo", 1'b1, 1'b0, 3, 9, 7, 5);
    tick();
    chk_idle("basic_idle");
    chk("basic_hold.up_re", 32'($signed(bus.out_up_re)), 3);

    // Extremes: every sum/difference is exact in WIDTH+1 bits.
    drive(1'b1, 1'b0, 255, -256, -256, 255);
    tick();
    chk_idle("ext_even");
    drive(1'b1, 1'b0, 255, -256, 255, -256);
    tick();
    idle();
    chk_out("ext_up", 1'b0, 1'b0, 510, -512, 0, 0);
    tick();
    chk_out("ext_lo", 1'b1, 1'b0, -1, -1, -511, 511);

    // Two full frames back to back, in_sof on pairs 0 and 16. The counter is
    // mid-frame (k = 4) beforehand, so the first in_sof must resync it.
    pur = 0; pui = 0; plr = 0; pli = 0;
    for (int j = 0; j < 34; j++) begin
      if (j < 32) begin
        ur = j * 8 - 128;
        ui = 100 - j * 5;
        lr = (j * j) / 4 - 50;
        li = -j * 3;
        drive(1'b1, (j % 16) == 0, ur, ui, lr, li);
        if (j % 2 == 1) begin
          e.sel = 1'b0; e.last = 1'b0;
          e.ure = pur + ur; e.uim = pui + ui; e.lre = pur - ur; e.lim = pui - ui;
          exp_q.push_back(e);
          e.sel = 1'b1; e.last = (j % 16) == 15;
          e.ure = plr + lr; e.uim = pli + li; e.lre = plr - lr; e.lim = pli - li;
          exp_q.push_back(e);
        end else begin
          pur = ur; pui = ui; plr = lr; pli = li;
        end
      end else begin
        idle();
      end
      tick();
      if (j >= 1 && j <= 32) begin
        chk($sformatf("frame_r%0d.qsize", j), exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk_out($sformatf("frame_r%0d", j), e.sel, e.last, e.ure, e.uim, e.lre, e.lim);
        end
      end else begin
        chk_idle($sformatf("frame_edge%0d", j));
      end
    end

    // Gaps: idle cycles between even and odd, with a stray in_sof that has
    // no in_valid and must be ignored; lower emission despite in_valid low.
    drive(1'b1, 1'b0, 1, 2, 3, 4);
    tick();
    chk_idle("gap_even");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 77, 77, 77, 77);
      tick();
      chk_idle($sformatf("gap_idle%0d", i));
    end
    drive(1'b1, 1'b0, 5, 6, 7, -8);
    tick();
    idle();
    chk_out("gap_up", 1'b0, 1'b0, 6, 8, -4, -4);
    tick();
    chk_out("gap_lo", 1'b1, 1'b0, 10, -4, -4, 12);

    // Resync: in_sof on an odd-position pair discards the held even sample.
    drive(1'b1, 1'b0, 20, 20, 99, 99);
    tick();
    chk_idle("resync_even");
    drive(1'b1, 1'b1, 30, 0, 1, 1);
    tick();
    chk_idle("resync_sof");
    drive(1'b1, 1'b0, 2, 3, 4, 5);
    tick();
    idle();
    chk_out("resync_up", 1'b0, 1'b0, 32, 3, 28, -3);
    tick();
    chk_out("resync_lo", 1'b1, 1'b0, 5, 6, -3, -4);

    // Reset the cycle after an odd input cancels the lower emission.
    drive(1'b1, 1'b0, 1, 1, 9, 9);
    tick();
    drive(1'b1, 1'b0, 1, 1, 1, 1);
    tick();
    chk_out("rstc_up", 1'b0, 1'b0, 2, 2, 0, 0);
    rst = 1'b1;
    idle();
    tick();
    chk_idle("rstc_in");
    chk("rstc_in.sel", {31'd0, bus.out_sel}, 0);
    rst = 1'b0;
    tick();
    chk_idle("rstc_after1");
    tick();
    chk_idle("rstc_after2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
